// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serializes a parallel word into an external shift register.
// A word is accepted in IDLE, sent one bit per cycle in SHIFT (MSB-first or
// LSB-first, with a programmable length), acknowledged by a one-cycle DONE
// pulse and followed by a programmable number of GAP cycles before the next
// word can be taken. Every output is a register or a decode of the state
// register, so nothing combinational leaks from the inputs to the outputs.
module shift_seq_ctrl #(
    parameter int W  = 8,
    parameter int LW = 4,
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] len,
    input  logic          msb_first,
    input  logic [GW-1:0] gap,
    input  logic          abort,
    output logic          sr_d,
    output logic          sr_en,
    output logic          sr_dir,
    output logic          busy,
    output logic          done,
    output logic [15:0]   word_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [LW-1:0] bitCnt_q, bitCnt_d;
    logic [GW-1:0] gapCnt_q, gapCnt_d;
    logic          msbFirst_q, msbFirst_d;
    logic          dir_q, dir_d;
    logic [15:0]   wordCnt_q, wordCnt_d;

    logic [LW-1:0] effLen;
    logic [LW-1:0] alignShift;

    // Effective length: 0 or anything wider than the word means a full word.
    // For MSB-first the word is pre-aligned so bit L-1 sits at the top and the
    // send loop can always take the MSB and shift left.
    always_comb begin
        effLen = len;
        if (len == '0 || len > LW'(W)) begin
            effLen = LW'(W);
        end
        alignShift = LW'(W) - effLen;
    end

    // Next-state and datapath update for the four-state sequencer.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bitCnt_d   = bitCnt_q;
        gapCnt_d   = gapCnt_q;
        msbFirst_d = msbFirst_q;
        dir_d      = dir_q;
        wordCnt_d  = wordCnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = SHIFT;
                    data_d     = msb_first ? (in_data << alignShift) : in_data;
                    bitCnt_d   = effLen - LW'(1);
                    gapCnt_d   = gap;
                    msbFirst_d = msb_first;
                    dir_d      = ~msb_first;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    data_d = msbFirst_q ? {data_q[W-2:0], 1'b0}
                                        : {1'b0, data_q[W-1:1]};
                    if (bitCnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bitCnt_d = bitCnt_q - LW'(1);
                    end
                end
            end
            DONE: begin
                wordCnt_d = wordCnt_q + 16'd1;
                state_d   = (gapCnt_q == '0) ? IDLE : GAP;
            end
            GAP: begin
                gapCnt_d = gapCnt_q - GW'(1);
                if (gapCnt_q == GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            bitCnt_q   <= '0;
            gapCnt_q   <= '0;
            msbFirst_q <= 1'b0;
            dir_q      <= 1'b0;
            wordCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bitCnt_q   <= bitCnt_d;
            gapCnt_q   <= gapCnt_d;
            msbFirst_q <= msbFirst_d;
            dir_q      <= dir_d;
            wordCnt_q  <= wordCnt_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sr_en    = (state_q == SHIFT);
    assign sr_d     = sr_en & (msbFirst_q ? data_q[W-1] : data_q[0]);
    assign sr_dir   = dir_q;
    assign word_cnt = wordCnt_q;

endmodule
